// File: rtl/cga_vram_pkg.sv
// rtl/cga_vram_pkg.sv - shared constants, FSM states and address helper for the CGA VRAM arbiter
package cga_vram_pkg;

    localparam int RAM_AW = 15;
    localparam int SLOT_W = 4;

    localparam logic [SLOT_W-1:0] FETCH0    = 4'd0;
    localparam logic [SLOT_W-1:0] FETCH1    = 4'd1;
    localparam logic [SLOT_W-1:0] CPU_FIRST = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } vram_state_t;

    // Graphics mode interleaves the two scan-row banks on the top address bit.
    function automatic logic [RAM_AW-1:0] disp_addr(
        input logic        gfx,
        input logic        bank,
        input logic [13:0] ma,
        input logic        b
    );
        return gfx ? {bank, ma[12:0], b} : {ma, b};
    endfunction

endpackage

// File: rtl/vram_slot_counter.sv
// rtl/vram_slot_counter.sv - character-period slot counter and CRTC character clock enable
module vram_slot_counter
    import cga_vram_pkg::*;
#(
    parameter int CHAR_CLKS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [SLOT_W-1:0] slot,
    output logic              char_ce
);

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(CHAR_CLKS - 1);

    // Resetting to the last slot makes char_ce fire in the first cycle after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot <= LAST;
        end else if (slot == LAST) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    assign char_ce = (slot == LAST);

endmodule

// File: rtl/cga_vram_arbiter.sv
// rtl/cga_vram_arbiter.sv - shares VRAM between CRTC display fetch and a single ISA CPU requester
module cga_vram_arbiter
    import cga_vram_pkg::*;
#(
    parameter int CHAR_CLKS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              char_ce,
    input  logic [13:0]       mem_addr,
    input  logic [4:0]        row_addr,
    input  logic              display_enable,
    input  logic              gfx_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_wait,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        pix_byte0,
    output logic [7:0]        pix_byte1
);

    logic [SLOT_W-1:0] slot;
    vram_state_t       state, state_nx, phase;
    logic              de_lat, fetch0, fetch1, cpu_slot, issue, issue_we;
    logic [7:0]        shadow0, shadow1;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              unused_row;

    vram_slot_counter #(.CHAR_CLKS(CHAR_CLKS)) u_slot_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .slot    (slot),
        .char_ce (char_ce)
    );

    // ISSUE is the IDLE cycle in which a request wins a CPU slot; it never sits in the state register.
    always_comb begin
        fetch0   = (slot == FETCH0) && display_enable;
        fetch1   = (slot == FETCH1) && de_lat;
        cpu_slot = (slot >= CPU_FIRST)
                 || ((slot == FETCH0) && !display_enable)
                 || ((slot == FETCH1) && !de_lat);
        issue    = (state == IDLE) && cpu_req && cpu_slot;
        phase    = issue ? ISSUE : state;
    end

    always_comb begin
        state_nx = state;
        case (phase)
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ram_addr = ram_addr_q;
        if (fetch0) begin
            ram_addr = disp_addr(gfx_mode, row_addr[0], mem_addr, 1'b0);
        end else if (fetch1) begin
            ram_addr = disp_addr(gfx_mode, row_addr[0], mem_addr, 1'b1);
        end else if (issue) begin
            ram_addr = cpu_addr;
        end
    end

    assign ram_we     = issue & cpu_we;
    assign ram_wdata  = ram_we ? cpu_wdata : 8'h00;
    assign cpu_ack    = (state == ACK);
    assign cpu_wait   = cpu_req & ~cpu_ack;
    assign unused_row = ^row_addr[4:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            de_lat     <= 1'b0;
            shadow0    <= 8'h00;
            shadow1    <= 8'h00;
            pix_byte0  <= 8'h00;
            pix_byte1  <= 8'h00;
            cpu_rdata  <= 8'h00;
            issue_we   <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state      <= state_nx;
            ram_addr_q <= ram_addr;
            if (slot == FETCH0) begin
                de_lat <= display_enable;
            end
            // Read data trails its address by one cycle, so each shadow loads one slot after its fetch.
            if (slot == FETCH1) begin
                shadow0 <= de_lat ? ram_rdata : 8'h00;
            end
            if (slot == CPU_FIRST) begin
                shadow1 <= de_lat ? ram_rdata : 8'h00;
            end
            if (char_ce) begin
                pix_byte0 <= shadow0;
                pix_byte1 <= shadow1;
            end
            if (issue) begin
                issue_we <= cpu_we;
            end
            if ((state == CAPTURE) && !issue_we) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// tb/tb_cga_vram_arbiter.sv - directed self-checking bench for cga_vram_arbiter
module tb_cga_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        char_ce;
    logic [13:0] mem_addr;
    logic [4:0]  row_addr;
    logic        display_enable;
    logic        gfx_mode;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  pix_byte0;
    logic [7:0]  pix_byte1;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [14:0] last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;

    cga_vram_arbiter #(.CHAR_CLKS(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .char_ce        (char_ce),
        .mem_addr       (mem_addr),
        .row_addr       (row_addr),
        .display_enable (display_enable),
        .gfx_mode       (gfx_mode),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .cpu_wait       (cpu_wait),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .pix_byte0      (pix_byte0),
        .pix_byte1      (pix_byte1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [14:0] a);
        case (a)
            15'h0246: return 8'hA5;
            15'h0247: return 8'h3C;
            15'h4020: return 8'h11;
            15'h4021: return 8'h22;
            15'h7FFF: return 8'h5A;
            default:  return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        ram_rdata <= rom(ram_addr);
        if (ram_we) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= ram_addr;
            last_wr_data <= ram_wdata;
        end
    end

    task automatic wait_char_ce();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = char_ce;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL char_ce_timeout: got no char_ce expected one within 20 cycles"); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_addr = '0; row_addr = '0; display_enable = 1'b0; gfx_mode = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (char_ce !== 1'b1) begin errors++; $display("FAIL rst_char_ce: got %b expected 1", char_ce); end
        checks++; if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL rst_ack_we: got %b%b expected 00", cpu_ack, ram_we); end
        checks++; if ({pix_byte0, pix_byte1} !== 16'h0000) begin errors++; $display("FAIL rst_pix: got %h expected 0000", {pix_byte0, pix_byte1}); end
        checks++; if (ram_addr !== 15'h0 || cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_addr_rdata: got %h/%h expected 0000/00", ram_addr, cpu_rdata); end
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            checks++; if (char_ce !== (k % 8 == 0)) begin errors++; $display("FAIL char_ce_cycle%0d: got %b expected %b", k, char_ce, (k % 8 == 0)); end
            checks++; if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL idle_we_ack%0d: got %b%b expected 00", k, ram_we, cpu_ack); end
        end
    endtask

    task automatic test_text_fetch();
        wait_char_ce();
        gfx_mode = 1'b0; mem_addr = 14'h0123; display_enable = 1'b1;
        @(negedge clk);
        checks++; if (ram_addr !== 15'h0246 || ram_we !== 1'b0) begin errors++; $display("FAIL text_addr0: got %h/%b expected 0246/0", ram_addr, ram_we); end
        @(negedge clk);
        checks++; if (ram_addr !== 15'h0247) begin errors++; $display("FAIL text_addr1: got %h expected 0247", ram_addr); end
        repeat (2) @(negedge clk);
        checks++; if (ram_addr !== 15'h0247) begin errors++; $display("FAIL addr_hold: got %h expected 0247", ram_addr); end
        wait_char_ce();
        checks++; if (pix_byte0 !== 8'h00) begin errors++; $display("FAIL text_pix_early: got %h expected 00", pix_byte0); end
        @(negedge clk);
        checks++; if (pix_byte0 !== 8'hA5 || pix_byte1 !== 8'h3C) begin errors++; $display("FAIL text_pix: got %h/%h expected A5/3C", pix_byte0, pix_byte1); end
    endtask

    task automatic test_gfx_fetch();
        wait_char_ce();
        gfx_mode = 1'b1; row_addr = 5'd1; mem_addr = 14'h0010;
        @(negedge clk);
        checks++; if (ram_addr !== 15'h4020) begin errors++; $display("FAIL gfx_addr0: got %h expected 4020", ram_addr); end
        @(negedge clk);
        checks++; if (ram_addr !== 15'h4021) begin errors++; $display("FAIL gfx_addr1: got %h expected 4021", ram_addr); end
        wait_char_ce();
        @(negedge clk);
        checks++; if (pix_byte0 !== 8'h11 || pix_byte1 !== 8'h22) begin errors++; $display("FAIL gfx_pix: got %h/%h expected 11/22", pix_byte0, pix_byte1); end
    endtask

    task automatic test_cpu_write_display();
        int wr_start;
        wait_char_ce();
        wr_start = wr_cnt;
        @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1000; cpu_wdata = 8'h55;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            checks++; if (ram_we !== (s == 2)) begin errors++; $display("FAIL wr_we_slot%0d: got %b expected %b", s, ram_we, (s == 2)); end
            checks++; if (cpu_ack !== (s == 4)) begin errors++; $display("FAIL wr_ack_slot%0d: got %b expected %b", s, cpu_ack, (s == 4)); end
            checks++; if (cpu_wait !== (s < 4)) begin errors++; $display("FAIL wr_wait_slot%0d: got %b expected %b", s, cpu_wait, (s < 4)); end
            if (s == 2) begin
                checks++; if (ram_addr !== 15'h1000 || ram_wdata !== 8'h55) begin errors++; $display("FAIL wr_bus: got %h/%h expected 1000/55", ram_addr, ram_wdata); end
            end
            if (s == 4) begin
                @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
            end
        end
        checks++; if (wr_cnt !== wr_start + 1 || last_wr_addr !== 15'h1000 || last_wr_data !== 8'h55)
            begin errors++; $display("FAIL wr_ram: got %0d writes %h/%h expected 1 write 1000/55", wr_cnt - wr_start, last_wr_addr, last_wr_data); end
    endtask

    task automatic test_cpu_read_blank();
        display_enable = 1'b0;
        @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h7FFF;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++; if (cpu_ack !== (s == 2)) begin errors++; $display("FAIL rd_ack_slot%0d: got %b expected %b", s, cpu_ack, (s == 2)); end
            if (s == 0) begin
                checks++; if (ram_addr !== 15'h7FFF || ram_we !== 1'b0) begin errors++; $display("FAIL rd_issue: got %h/%b expected 7FFF/0", ram_addr, ram_we); end
            end
        end
        checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h expected 5A", cpu_rdata); end
        @(posedge clk); #1 cpu_req = 1'b0;
        wait_char_ce();
        @(negedge clk);
        checks++; if (pix_byte0 !== 8'h00 || pix_byte1 !== 8'h00) begin errors++; $display("FAIL blank_pix: got %h/%h expected 00/00", pix_byte0, pix_byte1); end
        checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_hold: got %h expected 5A", cpu_rdata); end
    endtask

    task automatic test_reset_mid_access();
        wait_char_ce();
        display_enable = 1'b1; gfx_mode = 1'b0; mem_addr = 14'h0123;
        @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0246;
        repeat (3) @(negedge clk);
        checks++; if (ram_addr !== 15'h0246) begin errors++; $display("FAIL mid_issue: got %h expected 0246", ram_addr); end
        @(posedge clk); #1 reset_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 15'h0) begin errors++; $display("FAIL mid_rst_out: got %b/%b/%h expected 0/0/0000", cpu_ack, ram_we, ram_addr); end
        checks++; if (cpu_rdata !== 8'h00 || pix_byte0 !== 8'h00 || pix_byte1 !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h/%h/%h expected 00/00/00", cpu_rdata, pix_byte0, pix_byte1); end
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0 || char_ce !== 1'b1) begin errors++; $display("FAIL mid_rst_hold: got ack %b ce %b expected 0 1", cpu_ack, char_ce); end
        @(posedge clk); #1 reset_n = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h7FFF;
        @(negedge clk);
        checks++; if (char_ce !== 1'b1 || ram_addr !== 15'h7FFF || cpu_ack !== 1'b0) begin errors++; $display("FAIL last_slot_issue: got ce %b %h ack %b expected 1 7FFF 0", char_ce, ram_addr, cpu_ack); end
        @(negedge clk);
        checks++; if (ram_addr !== 15'h0246 || cpu_ack !== 1'b0) begin errors++; $display("FAIL overlap_slot0: got %h ack %b expected 0246 0", ram_addr, cpu_ack); end
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A || ram_addr !== 15'h0247)
            begin errors++; $display("FAIL overlap_slot1: got ack %b %h %h expected 1 5A 0247", cpu_ack, cpu_rdata, ram_addr); end
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0 || cpu_wait !== 1'b0) begin errors++; $display("FAIL post_ack: got %b%b expected 00", cpu_ack, cpu_wait); end
    endtask

    initial begin
        test_reset();
        test_text_fetch();
        test_gfx_fetch();
        test_cpu_write_display();
        test_cpu_read_blank();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cga_vram_arbiter.md
# cga_vram_arbiter

Sequences the shared video RAM between the CRTC display fetch and ISA CPU accesses. It generates the character-clock enable that steps the 6845-style CRTC, and fetches two display bytes per character period (char/attr in text mode, two pixel bytes in graphics mode). It grants the remaining RAM cycles to a single CPU requester with a wait/ack handshake. It sits between the CRTC, the pixel serializer, the ISA bus interface and the synchronous VRAM.

## Interface
Parameters:
- CHAR_CLKS, 8, clk cycles per character period; legal range 4..16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- char_ce  out  1  character clock enable to CRTC `divclk`; high for one clk per period.
- mem_addr  in  14  CRTC memory address, stable from slot 0 to slot CHAR_CLKS-1.
- row_addr  in  5  CRTC scan row; bit 0 selects the graphics bank.
- display_enable  in  1  CRTC active-display flag.
- gfx_mode  in  1  1 = graphics addressing, 0 = text addressing.
- cpu_req  in  1  CPU access request, held high until ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  15  CPU byte address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid with ack, held until the next CPU read completes.
- cpu_wait  out  1  IOCHRDY-low request, `cpu_req & ~cpu_ack`.
- ram_addr  out  15  VRAM byte address.
- ram_we  out  1  VRAM write strobe.
- ram_wdata  out  8  VRAM write data.
- ram_rdata  in  8  VRAM read data, valid the cycle after the address.
- pix_byte0, pix_byte1  out  8 each  display bytes for the serializer.

## Operation
- slot counter runs 0..CHAR_CLKS-1 and wraps to 0; char_ce = (slot == CHAR_CLKS-1).
- Display address for byte b (0/1):
  - text: {mem_addr[13:0], b}
  - graphics: {row_addr[0], mem_addr[12:0], b}
- de_lat is display_enable sampled at the edge ending slot 0.
- When display_enable = 1 in slot 0:
  - slot 0 issues the byte0 read; slot 1 issues the byte1 read.
  - shadow0 is captured at the edge ending slot 1; shadow1 at the edge ending slot 2.
- When display_enable = 0 in slot 0, slots 0 and 1 become CPU slots and both shadows load 0x00.
- pix_byte0/1 load the shadows at the edge where char_ce is high.
- CPU slots are 2..CHAR_CLKS-1, plus 0..1 when blanked.
- FSM IDLE → ISSUE → CAPTURE → ACK → IDLE:
  - IDLE → ISSUE: in a CPU slot with cpu_req high, drive ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata for one cycle.
  - ISSUE → CAPTURE: register ram_rdata into cpu_rdata; for writes cpu_rdata is unchanged.
  - CAPTURE → ACK: cpu_ack = 1 for one cycle.
  - ACK → IDLE.
- req is ignored in the ACK state; the requester drops req at the edge ending the ack cycle.
- A request that misses a CPU slot waits for the next one.
- Display fetch always has priority. The FSM never issues in display slots, but CAPTURE/ACK may overlap them.
- ram_we is only ever high in an ISSUE cycle.
- When no access is issued, ram_addr holds the last value and ram_we = 0.

## Timing
- Reset values:
  - slot = CHAR_CLKS-1 so that char_ce is high in the first cycle after release.
  - FSM = IDLE.
  - All outputs 0 except char_ce.
  - de_lat = 0.
- Reset mid-access aborts the access; no ack is produced.
- CPU latency from issue is 2 cycles to ack.
- Worst case from req to ack (CHAR_CLKS = 8, displaying) is 4 cycles: req arriving at slot 0.
- Display data latency: the mem_addr set at char_ce edge N appears on pix_byte at char_ce edge N+1.
- Issue in slot CHAR_CLKS-1 is legal; its capture and ack run into slots 0–1 of the next period.

## Structure
- Package cga_vram_pkg holds:
  - RAM_AW = 15
  - the FSM state enum {IDLE, ISSUE, CAPTURE, ACK}
  - slot constants FETCH0 = 0, FETCH1 = 1, CPU_FIRST = 2
- The sub-module vram_slot_counter (slot counter and char_ce) is natural; the FSM, address muxing and shadows stay in the top.

## Test plan
- Reset release, CHAR_CLKS = 8 → char_ce high in cycle 0, then every 8 cycles; cpu_ack, ram_we and pix bytes are 0.
- Text mode, mem_addr = 0x0123, display on, RAM returns A5/3C → ram_addr 0x0246 in slot 0 and 0x0247 in slot 1; pix = A5/3C after the next char_ce.
- Graphics mode, row_addr = 1, mem_addr = 0x0010 → ram_addr 0x4020/0x4021.
- CPU write 0x55 to 0x1000, req asserted at slot 0 while displaying → ram_we only in slot 2; ack in slot 4; cpu_wait high in slots 0–3.
- Blanked period, CPU read of 0x7FFF raised at slot 0 → issue in slot 0, ack in slot 2, cpu_rdata = RAM value; pix bytes = 0.
- reset_n low during CAPTURE → no ack; all outputs 0; the next request completes normally.
